step_sequencer: RTL

- Parametrised micro-step (T-state) sequencer for the processor control path.
- Generates the step index, a one-hot step decode and fetch/last-step flags that drive the control-word decoder.
- Handles variable-length instructions through early termination, pipeline stalls and a deferred halt.
- Keeps a retired-instruction count for debug and test.

---
 rtl/step_seq_pkg.sv | 17 +
 rtl/step_seq_if.sv | 45 ++++
 rtl/step_decoder.sv | 22 ++
 rtl/step_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// Shared definitions for the micro-step sequencer.
// Contents:
//   step_state_e   sequencer state encoding (IDLE / RUN / HALTED)
//   Def*           default geometry for sequencer instances and bus interfaces
package step_seq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StHalted = 2'b10
    } step_state_e;

    localparam int unsigned DefNumSteps   = 8;
    localparam int unsigned DefFetchSteps = 2;
    localparam int unsigned DefCntW       = 8;

endpackage

// File: rtl/step_seq_if.sv
// Control/status bundle between the processor control path and the step sequencer.
// Signals:
//   step_seq_start/hold/done/halt   control requests into the sequencer
//   step_seq_count                  current step index (STEP_W)
//   step_seq_onehot                 one-hot step decode (NUM_STEPS)
//   step_seq_fetch/last             step classification flags
//   step_seq_retire                 one-cycle pulse after an instruction retires
//   step_seq_instr_cnt              retired-instruction count (CNT_W)
//   step_seq_running/halted         state flags
// Modports: master drives the requests, slave is the sequencer.
interface step_seq_if
    import step_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS = DefNumSteps,
    parameter int unsigned CNT_W     = DefCntW
) ();

    localparam int unsigned STEP_W = $clog2(NUM_STEPS);

    logic                 step_seq_start;
    logic                 step_seq_hold;
    logic                 step_seq_done;
    logic                 step_seq_halt;
    logic [STEP_W-1:0]    step_seq_count;
    logic [NUM_STEPS-1:0] step_seq_onehot;
    logic                 step_seq_fetch;
    logic                 step_seq_last;
    logic                 step_seq_retire;
    logic [CNT_W-1:0]     step_seq_instr_cnt;
    logic                 step_seq_running;
    logic                 step_seq_halted;

    modport master (
        output step_seq_start, step_seq_hold, step_seq_done, step_seq_halt,
        input  step_seq_count, step_seq_onehot, step_seq_fetch, step_seq_last,
        input  step_seq_retire, step_seq_instr_cnt, step_seq_running, step_seq_halted
    );

    modport slave (
        input  step_seq_start, step_seq_hold, step_seq_done, step_seq_halt,
        output step_seq_count, step_seq_onehot, step_seq_fetch, step_seq_last,
        output step_seq_retire, step_seq_instr_cnt, step_seq_running, step_seq_halted
    );

endinterface

// File: rtl/step_decoder.sv
// One-hot decoder for the step index.
// Ports:
//   en_i      decode enable; output is all-zero when low
//   idx_i     step index (STEP_W bits)
//   onehot_o  1 << idx_i when enabled (NUM_STEPS bits)
module step_decoder #(
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned STEP_W    = $clog2(NUM_STEPS)
) (
    input  logic                 en_i,
    input  logic [STEP_W-1:0]    idx_i,
    output logic [NUM_STEPS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o = NUM_STEPS'(1) << idx_i;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Micro-step (T-state) sequencer for the processor control path.
// Walks the step index 0..NUM_STEPS-1 per instruction, supports early termination (done),
// stalls (hold) and a sticky halt taken at the next instruction boundary, and counts
// retired instructions.
// Ports:
//   step_seq_clk   clock, rising edge
//   step_seq_rst   synchronous active-high reset
//   bus            step_seq_if slave: requests in, step index/decode/flags/counter out
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS   = DefNumSteps,
    parameter int unsigned FETCH_STEPS = DefFetchSteps,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic     step_seq_clk,
    input  logic     step_seq_rst,
    step_seq_if.slave bus
);

    localparam int unsigned STEP_W = $clog2(NUM_STEPS);
    localparam logic [STEP_W-1:0] FetchLim = STEP_W'(FETCH_STEPS);
    localparam logic [STEP_W-1:0] LastStep = STEP_W'(NUM_STEPS - 1);

    step_state_e       state_q, state_d;
    logic [STEP_W-1:0] count_q, count_d;
    logic              halt_pending_q, halt_pending_d;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    logic running;
    logic last;
    logic retire_ev;

    assign running = (state_q == StRun);
    assign last    = running && (count_q == LastStep);
    // done ends the instruction even while stalled
    assign retire_ev = running && (bus.step_seq_done || (last && !bus.step_seq_hold));

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        halt_pending_d = halt_pending_q;
        retire_d       = 1'b0;
        instr_cnt_d    = instr_cnt_q;
        unique case (state_q)
            StIdle: begin
                count_d = '0;
                if (bus.step_seq_start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (retire_ev) begin
                    count_d     = '0;
                    retire_d    = 1'b1;
                    instr_cnt_d = instr_cnt_q + CNT_W'(1);
                    // a halt arriving on the boundary cycle is taken immediately
                    if (halt_pending_q || bus.step_seq_halt) begin
                        state_d        = StHalted;
                        halt_pending_d = 1'b0;
                    end
                end else begin
                    halt_pending_d = halt_pending_q | bus.step_seq_halt;
                    if (!bus.step_seq_hold) begin
                        count_d = count_q + STEP_W'(1);
                    end
                end
            end
            StHalted: begin
                count_d = '0;
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge step_seq_clk) begin
        if (step_seq_rst) begin
            state_q        <= StIdle;
            count_q        <= '0;
            halt_pending_q <= 1'b0;
            retire_q       <= 1'b0;
            instr_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            halt_pending_q <= halt_pending_d;
            retire_q       <= retire_d;
            instr_cnt_q    <= instr_cnt_d;
        end
    end

    step_decoder #(
        .NUM_STEPS (NUM_STEPS),
        .STEP_W    (STEP_W)
    ) u_step_decoder (
        .en_i     (running),
        .idx_i    (count_q),
        .onehot_o (bus.step_seq_onehot)
    );

    assign bus.step_seq_count     = count_q;
    assign bus.step_seq_fetch     = running && (count_q < FetchLim);
    assign bus.step_seq_last      = last;
    assign bus.step_seq_retire    = retire_q;
    assign bus.step_seq_instr_cnt = instr_cnt_q;
    assign bus.step_seq_running   = running;
    assign bus.step_seq_halted    = (state_q == StHalted);

endmodule
